// File: rtl/sponge_ctrl.sv
// SHAKE sponge sequencer: clears the Keccak state, absorbs message lanes, pads,
// and squeezes output lanes, handing each full rate block to an external permutation core.
module sponge_ctrl #(
    parameter int RATE_LANES = 21,
    parameter int W          = 64,
    parameter int OLEN_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OLEN_W-1:0] out_lanes,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_lane,
    input  logic              in_last,
    output logic              state_clear,
    output logic [2:0]        lane_x,
    output logic [2:0]        lane_y,
    output logic              lane_xor_en,
    output logic [W-1:0]      lane_xor_data,
    input  logic [W-1:0]      lane_rd_data,
    output logic              perm_start,
    input  logic              perm_done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_lane,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [4:0]        K_LAST   = 5'(RATE_LANES - 1);
    localparam logic [4:0]        K_ONE    = 5'd1;
    localparam logic [2:0]        X_LAST   = 3'((RATE_LANES - 1) % 5);
    localparam logic [2:0]        Y_LAST   = 3'((RATE_LANES - 1) / 5);
    localparam logic [OLEN_W-1:0] ONE      = OLEN_W'(1);
    localparam logic [W-1:0]      PAD_DOM  = W'(8'h1F);
    localparam logic [W-1:0]      PAD_FIN  = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]      PAD_BOTH = PAD_FIN | PAD_DOM;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_ABSORB, S_PAD, S_PERM_A, S_PERM_P, S_PERM_S, S_SQUEEZE, S_DONE
    } state_t;

    state_t            st;
    logic [4:0]        k;
    logic [OLEN_W-1:0] olen;
    logic [OLEN_W-1:0] cnt;
    logic              pad_wr;
    logic              pad_two;
    logic [W-1:0]      pad_data;
    logic              perm_q;
    logic              accept_in;
    logic              accept_out;

    // Lane index k = 5y + x advanced without a divider.
    function automatic logic [5:0] step_xy(input logic [2:0] x, input logic [2:0] y);
        if (x == 3'd4) return {3'd0, y + 3'd1};
        else           return {x + 3'd1, y};
    endfunction

    assign accept_in     = in_valid & in_ready;
    assign accept_out    = out_valid & out_ready;
    // Gated by reset so nothing reaches the state array or core during the reset cycle.
    assign lane_xor_en   = ~reset & (accept_in | pad_wr);
    assign lane_xor_data = in_ready ? in_lane : pad_data;
    assign perm_start    = perm_q & ~reset;
    assign out_lane      = out_valid ? lane_rd_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_IDLE;
            k           <= '0;
            lane_x      <= '0;
            lane_y      <= '0;
            olen        <= '0;
            cnt         <= '0;
            in_ready    <= 1'b0;
            state_clear <= 1'b0;
            pad_wr      <= 1'b0;
            pad_two     <= 1'b0;
            pad_data    <= '0;
            perm_q      <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_clear <= 1'b0;
            perm_q      <= 1'b0;
            done        <= 1'b0;
            case (st)
                S_IDLE: if (start) begin
                    st          <= S_CLEAR;
                    state_clear <= 1'b1;
                    busy        <= 1'b1;
                    olen        <= (out_lanes == '0) ? ONE : out_lanes;
                    cnt         <= '0;
                end
                S_CLEAR: begin
                    st               <= S_ABSORB;
                    k                <= '0;
                    {lane_x, lane_y} <= '0;
                    in_ready         <= 1'b1;
                end
                S_ABSORB: if (accept_in) begin
                    k                <= k + K_ONE;
                    {lane_x, lane_y} <= step_xy(lane_x, lane_y);
                    if (in_last && k == K_LAST) begin
                        st               <= S_PERM_P;
                        in_ready         <= 1'b0;
                        perm_q           <= 1'b1;
                        k                <= '0;
                        {lane_x, lane_y} <= '0;
                    end else if (in_last) begin
                        // Pad starts at the lane after the final message lane.
                        st       <= S_PAD;
                        in_ready <= 1'b0;
                        pad_wr   <= 1'b1;
                        pad_two  <= (k + K_ONE != K_LAST);
                        pad_data <= (k + K_ONE == K_LAST) ? PAD_BOTH : PAD_DOM;
                    end else if (k == K_LAST) begin
                        st               <= S_PERM_A;
                        in_ready         <= 1'b0;
                        perm_q           <= 1'b1;
                        k                <= '0;
                        {lane_x, lane_y} <= '0;
                    end
                end
                S_PAD: begin
                    if (pad_two) begin
                        pad_two  <= 1'b0;
                        pad_data <= PAD_FIN;
                        lane_x   <= X_LAST;
                        lane_y   <= Y_LAST;
                    end else begin
                        st       <= S_PERM_S;
                        pad_wr   <= 1'b0;
                        pad_data <= '0;
                        perm_q   <= 1'b1;
                    end
                end
                S_PERM_A: if (perm_done) begin
                    st       <= S_ABSORB;
                    in_ready <= 1'b1;
                end
                S_PERM_P: if (perm_done) begin
                    st               <= S_PAD;
                    pad_wr           <= 1'b1;
                    pad_two          <= 1'b1;
                    pad_data         <= PAD_DOM;
                    {lane_x, lane_y} <= '0;
                end
                S_PERM_S: if (perm_done) begin
                    st               <= S_SQUEEZE;
                    k                <= '0;
                    {lane_x, lane_y} <= '0;
                    out_valid        <= 1'b1;
                    out_last         <= (cnt == olen - ONE);
                end
                S_SQUEEZE: if (accept_out) begin
                    cnt <= cnt + ONE;
                    if (out_last) begin
                        st        <= S_DONE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                    end else if (k == K_LAST) begin
                        st               <= S_PERM_S;
                        out_valid        <= 1'b0;
                        perm_q           <= 1'b1;
                        k                <= '0;
                        {lane_x, lane_y} <= '0;
                    end else begin
                        k                <= k + K_ONE;
                        {lane_x, lane_y} <= step_xy(lane_x, lane_y);
                        out_last         <= (cnt + ONE == olen - ONE);
                    end
                end
                S_DONE: begin
                    st   <= S_IDLE;
                    busy <= 1'b0;
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sponge_ctrl.md
Name: sponge_ctrl

Overview:
Sequences the SHAKE sponge around the 5x5x64 Keccak state array and an external Keccak-f[1600] permutation core. The block does four things:
- clears the state;
- XOR-absorbs message lanes at rate-lane positions;
- applies SHAKE padding (domain 0x1F, final bit 0x80);
- squeezes a requested number of output lanes, starting a permutation whenever a rate block is exhausted.

Lane k maps to state position x = k mod 5, y = k div 5, matching the bitstring offset 64*(5y+x).

Parameters:
RATE_LANES, 21, rate in 64-bit lanes (21 = SHAKE128, 17 = SHAKE256). Legal range 2..24.
W, 64, lane width in bits.
OLEN_W, 16, width of the output-lane count.

Ports:
clk  in  1  clock; all logic on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  begin a new hash; accepted only in IDLE
out_lanes  in  OLEN_W  number of output lanes, latched on start; 0 is treated as 1
in_valid  in  1  message lane valid
in_ready  out  1  high in ABSORB only
in_lane  in  W  message lane, little-endian bytes
in_last  in  1  marks the final message lane; messages are at least 1 lane
state_clear  out  1  one-cycle pulse: state array zeroed
lane_x  out  3  current lane column
lane_y  out  3  current lane row
lane_xor_en  out  1  XOR lane_xor_data into state[lane_x][lane_y] this cycle
lane_xor_data  out  W  data to XOR
lane_rd_data  in  W  state[lane_x][lane_y], combinational read
perm_start  out  1  one-cycle pulse starting the permutation
perm_done  in  1  one-cycle pulse from the permutation core
out_valid  out  1  squeezed lane valid
out_ready  in  1  consumer ready
out_lane  out  W  squeezed lane (= lane_rd_data)
out_last  out  1  final squeezed lane
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last lane is squeezed

Behaviour:
Reset:
- Forces IDLE. Lane counter = 0, output count = 0.
- All outputs = 0; lane_x = lane_y = 0.
- No XOR write or perm_start is issued in the reset cycle or the cycle after.
- Reset mid-operation abandons the hash. A perm_done arriving later is ignored.

Lane indexing:
- Lane counter k runs 0..RATE_LANES-1 and drives (lane_x, lane_y) from registered counters.
- Wraps to 0 after RATE_LANES-1.

IDLE:
- start=1 → CLEAR. Latch max(out_lanes, 1). start in any other state is ignored.

CLEAR:
- state_clear=1 for exactly one cycle; k := 0 → ABSORB.

ABSORB:
- in_ready=1. lane_xor_en = in_valid & in_ready (combinational), lane_xor_data = in_lane, written at lane k.
- On accept, k += 1.
- Accept with in_last=0 at k = RATE_LANES-1 → PERM_A (block full); k := 0.
- Accept with in_last=1:
  - if k < RATE_LANES-1: → PAD with pad index p = k+1;
  - if k = RATE_LANES-1: → PERM_P (permute, then pad a fresh block with p = 0).

PAD (registered writes, one per cycle):
- If p = RATE_LANES-1: one cycle, XOR 64'h8000_0000_0000_001F at lane p.
- Otherwise: cycle 1 XOR 64'h1F at lane p; cycle 2 XOR 64'h8000_0000_0000_0000 at lane RATE_LANES-1.
- Then → PERM_S.

PERM_A / PERM_P / PERM_S:
- perm_start pulses on the cycle of entry. The block waits, with all writes and handshakes idle, until perm_done.
- After perm_done:
  - PERM_A → ABSORB;
  - PERM_P → PAD (p = 0);
  - PERM_S / squeeze refill → SQUEEZE with k = 0.
- Minimum latency from perm_start to the next action is 1 cycle after perm_done.

SQUEEZE:
- out_valid=1, out_lane = lane_rd_data at lane k.
- On out_valid & out_ready: output count += 1, k += 1.
- out_last = (count == latched out_lanes - 1).
- Accept of the last lane → DONE.
- Accept at k = RATE_LANES-1 with lanes still remaining → PERM_S (refill); k := 0.
- out_valid is held with stable data while out_ready=0.

DONE:
- done=1 for one cycle → IDLE. busy drops the same cycle as IDLE entry.

Invariants:
- perm_start is never asserted while a permutation is in flight.
- lane_xor_en and perm_start are never high in the same cycle.

Test Plan:
- SHAKE128 (RATE 21), out_lanes=1, single lane 0x0123456789ABCDEF with in_last → state_clear pulse; XOR writes: lane0 = msg, lane1 = 0x1F, lane20 (x=0, y=4) = 0x8000...0; one perm_start; after perm_done, one out_lane = lane_rd_data with out_last=1, then done pulse.
- 20-lane message with in_last on lane 19 → single combined write of 0x8000_0000_0000_001F at lane 20, no separate 0x1F write.
- Exactly 21-lane message → perm_start after lane 20 with in_last; after perm_done, writes 0x1F at lane 0 and 0x80.. at lane 20, then a second perm_start.
- out_lanes=25, out_ready toggled 1/0 each cycle → 21 lanes out, refill perm_start, then 4 lanes with out_last on the 25th; out_lane stable while stalled.
- Reset asserted in ABSORB after 5 lanes, then a stray perm_done pulse → IDLE, all outputs 0, no perm_start; a new start runs a clean hash.
- start asserted during SQUEEZE and out_lanes=0 → start ignored; a fresh hash with out_lanes=0 squeezes exactly 1 lane.
